// File: rtl/processor_datapath.sv
// processor_datapath: IR, R0..R7, A, G, shared bus mux and add/sub/AND ALU driven by the control FSM.
// Optional registered ALU flags when DATAPATH_FLAGS_EN is defined.
module processor_datapath #(
    parameter int DW      = 16,
    parameter int NREG    = 8,
    parameter int SEL_IMM = 8,
    parameter int SEL_G   = 9
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [DW-1:0]   din,
    input  logic            ir_in_n,
    input  logic            a_in_n,
    input  logic            g_in_n,
    input  logic [NREG-1:0] rx_in_n,
    input  logic [3:0]      sel,
    input  logic [1:0]      op,
    input  logic            add_sub_ctrl,
    output logic [DW-1:0]   ir_out,
    output logic [DW-1:0]   bus_out,
    output logic [DW-1:0]   g_out,
    input  logic [2:0]      dbg_sel,
    output logic [DW-1:0]   dbg_data,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_c
);
    logic [DW-1:0] r_ir, r_a, r_g;
    logic [DW-1:0] r_r [NREG];
    logic [DW-1:0] w_imm, w_bus, w_res;
    logic [DW:0]   w_sum;
    assign w_imm = (r_ir[15:13] == 3'b001) ? {r_ir[7:0], 8'h00} : {7'b0, r_ir[8:0]};
    // Unknown or out-of-range selects fall through to zero so the bus never floats.
    always_comb begin
        w_bus = '0;
        case (sel)
            4'(SEL_IMM): w_bus = w_imm;
            4'(SEL_G):   w_bus = r_g;
            default:     if (!sel[3]) w_bus = r_r[sel[2:0]];
        endcase
    end
    assign w_sum = {1'b0, r_a} + {1'b0, add_sub_ctrl ? ~w_bus : w_bus} + {{DW{1'b0}}, add_sub_ctrl};
    assign w_res = (op == 2'b00) ? w_sum[DW-1:0] : (op == 2'b01) ? (r_a & w_bus) : '0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ir <= '0;
            r_a  <= '0;
            r_g  <= '0;
            for (int k = 0; k < NREG; k++) r_r[k] <= '0;
        end else begin
            if (!ir_in_n) r_ir <= din;
            if (!a_in_n) r_a <= w_bus;
            if (!g_in_n) r_g <= w_res;
            for (int k = 0; k < NREG; k++) if (!rx_in_n[k]) r_r[k] <= w_bus;
        end
    end
`ifdef DATAPATH_FLAGS_EN
    logic r_z, r_n, r_c;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_c <= 1'b0;
        end else if (!g_in_n) begin
            r_z <= (w_res == '0);
            r_n <= w_res[DW-1];
            r_c <= (op == 2'b00) & w_sum[DW];
        end
    end
    assign flag_z = r_z;
    assign flag_n = r_n;
    assign flag_c = r_c;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_c = 1'b0;
`endif
    assign ir_out   = r_ir;
    assign bus_out  = w_bus;
    assign g_out    = r_g;
    assign dbg_data = r_r[dbg_sel];
endmodule

// File: tb/tb_processor_datapath.sv
// tb_processor_datapath: directed vectors against processor_datapath.
module tb_processor_datapath;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] din;
    logic        ir_in_n, a_in_n, g_in_n;
    logic [7:0]  rx_in_n;
    logic [3:0]  sel;
    logic [1:0]  op;
    logic        add_sub_ctrl;
    logic [15:0] ir_out, bus_out, g_out, dbg_data;
    logic [2:0]  dbg_sel;
    logic        flag_z, flag_n, flag_c;
    int          checks = 0;
    int          errors = 0;
`ifdef DATAPATH_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    processor_datapath dut (
        .clk(clk), .reset_n(reset_n), .din(din), .ir_in_n(ir_in_n), .a_in_n(a_in_n),
        .g_in_n(g_in_n), .rx_in_n(rx_in_n), .sel(sel), .op(op), .add_sub_ctrl(add_sub_ctrl),
        .ir_out(ir_out), .bus_out(bus_out), .g_out(g_out), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
        ir_in_n = 1'b1;
        a_in_n  = 1'b1;
        g_in_n  = 1'b1;
        rx_in_n = 8'hFF;
    endtask
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic chk_reg(input string tag, input int k, input logic [15:0] exp);
        dbg_sel = 3'(k);
        #0;
        chk(tag, dbg_data, exp);
    endtask
    task automatic chk_flags(input string tag, input bit z, input bit n, input bit c);
        chk(tag, {13'b0, flag_z, flag_n, flag_c}, {13'b0, FL & z, FL & n, FL & c});
    endtask
    task automatic ld_ir(input logic [15:0] d);
        din = d;
        ir_in_n = 1'b0;
        step();
    endtask
    task automatic mv(input logic [3:0] s, input logic [7:0] rx);
        sel = s;
        rx_in_n = rx;
        step();
    endtask
    task automatic lda(input logic [3:0] s);
        sel = s;
        a_in_n = 1'b0;
        step();
    endtask
    task automatic alu(input logic [3:0] s, input logic [1:0] o, input logic sub);
        sel = s;
        op = o;
        add_sub_ctrl = sub;
        g_in_n = 1'b0;
        step();
    endtask
    initial begin
        reset_n = 1'b0; din = '0; ir_in_n = 1'b1; a_in_n = 1'b1; g_in_n = 1'b1;
        rx_in_n = 8'hFF; sel = 4'd0; op = 2'b00; add_sub_ctrl = 1'b0; dbg_sel = 3'd0;
        step();
        reset_n = 1'b1;
        chk("init_ir", ir_out, 16'h0000);
        chk("init_g", g_out, 16'h0000);
        // Build R3=1234 as 1200 + 0034.
        ld_ir(16'h2012);
        chk("ir_load", ir_out, 16'h2012);
        sel = 4'd8; #1;
        chk("bus_mvt", bus_out, 16'h1200);
        lda(4'd8);
        ld_ir(16'h0034);
        sel = 4'd8; #1;
        chk("bus_imm", bus_out, 16'h0034);
        alu(4'd8, 2'b00, 1'b0);
        chk("add_g", g_out, 16'h1234);
        chk_flags("add_flags", 1'b0, 1'b0, 1'b0);
        mv(4'd9, 8'hF7);
        chk_reg("r3_load", 3, 16'h1234);
        chk_reg("r2_hold", 2, 16'h0000);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) chk_reg($sformatf("rst_r%0d", k), k, 16'h0000);
        chk("rst_ir", ir_out, 16'h0000);
        chk("rst_g", g_out, 16'h0000);
        chk_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        alu(4'd8, 2'b01, 1'b0);
        chk("rst_a", g_out, 16'h0000);
        ld_ir(16'h1105);
        mv(4'd8, 8'hFE);
        chk_reg("mv_imm_r0", 0, 16'h0105);
        ld_ir(16'h32AB);
        mv(4'd8, 8'hFD);
        chk_reg("mvt_r1", 1, 16'hAB00);
        ld_ir(16'h0005);
        mv(4'd8, 8'hFB);
        ld_ir(16'h0003);
        lda(4'd8);
        alu(4'd2, 2'b00, 1'b1);
        chk("sub_g", g_out, 16'hFFFE);
        chk_flags("sub_flags", 1'b0, 1'b1, 1'b0);
        lda(4'd9);
        ld_ir(16'h0002);
        alu(4'd8, 2'b00, 1'b0);
        chk("wrap_g", g_out, 16'h0000);
        chk_flags("wrap_flags", 1'b1, 1'b0, 1'b1);
        alu(4'd9, 2'b00, 1'b0);
        chk("g_loop0", g_out, 16'hFFFE);
        alu(4'd9, 2'b00, 1'b0);
        chk("g_loop1", g_out, 16'hFFFC);
        chk_flags("g_loop_flags", 1'b0, 1'b1, 1'b1);
        // R4=3C3C then A=F0F0, each assembled through G.
        ld_ir(16'h203C);
        lda(4'd8);
        ld_ir(16'h003C);
        alu(4'd8, 2'b00, 1'b0);
        mv(4'd9, 8'hEF);
        chk_reg("r4_load", 4, 16'h3C3C);
        ld_ir(16'h20F0);
        lda(4'd8);
        ld_ir(16'h00F0);
        alu(4'd8, 2'b00, 1'b0);
        lda(4'd9);
        alu(4'd4, 2'b01, 1'b0);
        chk("and_g", g_out, 16'h3030);
        chk_flags("and_flags", 1'b0, 1'b0, 1'b0);
        alu(4'd4, 2'b10, 1'b0);
        chk("op10_g", g_out, 16'h0000);
        chk_flags("op10_flags", 1'b1, 1'b0, 1'b0);
        sel = 4'd12; #1;
        chk("bus_sel12", bus_out, 16'h0000);
        mv(4'd12, 8'h00);
        for (int k = 0; k < 8; k++) chk_reg($sformatf("clr_r%0d", k), k, 16'h0000);
        ld_ir(16'h0007);
        mv(4'd8, 8'hDF);
        sel = 4'd5;
        rx_in_n = 8'hDF;
        a_in_n = 1'b0;
        step();
        chk_reg("self_r5", 5, 16'h0007);
        alu(4'd5, 2'b01, 1'b0);
        chk("self_a", g_out, 16'h0007);
        chk_reg("r0_hold", 0, 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
